// File: rtl/mux_stream_n.sv
// N-to-1 valid/ready stream mux with a single registered output stage.
// Optional packet lock (in_last/out_last) is enabled by defining MUX_STREAM_N_PKT_LOCK_EN.
module mux_stream_n #(
    parameter int NUM_CH  = 8,
    parameter int DATA_W  = 8,
    parameter int SEL_W   = 3,
    parameter int RR_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
`ifdef MUX_STREAM_N_PKT_LOCK_EN
    input  logic [NUM_CH-1:0]        in_last,
    output logic                     out_last,
`endif
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready
);

    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic [SEL_W-1:0]  ch_p1;
    logic [SEL_W-1:0]  last_grant;

    logic              load_en;
    logic              grant_vld;
    logic [SEL_W-1:0]  grant;
    logic              sel_vld;
    logic              rr_vld;
    logic [SEL_W-1:0]  rr_idx;
    logic [DATA_W-1:0] data_mux;
    int                idx;

`ifdef MUX_STREAM_N_PKT_LOCK_EN
    logic              last_p1;
    logic              lock_vld;
    logic [SEL_W-1:0]  lock_ch;
    logic              lock_ch_vld;
    logic              last_mux;
`endif

    assign load_en = !vld_p1 || out_ready;

    always_comb begin
        sel_vld  = 1'b0;
        rr_vld   = 1'b0;
        rr_idx   = '0;
        idx      = 0;
        data_mux = '0;
        in_ready = '0;

        for (int i = 0; i < NUM_CH; i++) begin
            if (i == int'(sel)) sel_vld = in_valid[i];
        end

        // Scan starts one past the previous winner so every channel gets a turn.
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last_grant) + k) % NUM_CH;
            if (!rr_vld && in_valid[idx]) begin
                rr_vld = 1'b1;
                rr_idx = SEL_W'(idx);
            end
        end

        if (RR_MODE != 0) begin
            grant     = rr_idx;
            grant_vld = rr_vld;
        end else begin
            grant     = sel;
            grant_vld = sel_vld;
        end

`ifdef MUX_STREAM_N_PKT_LOCK_EN
        lock_ch_vld = 1'b0;
        last_mux    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i == int'(lock_ch)) lock_ch_vld = in_valid[i];
        end
        // A packet in progress owns the output until its last beat.
        if (lock_vld) begin
            grant     = lock_ch;
            grant_vld = lock_ch_vld;
        end
`endif

        grant_vld = grant_vld && load_en && !rst;

        for (int i = 0; i < NUM_CH; i++) begin
            if (i == int'(grant)) begin
                in_ready[i] = grant_vld;
                data_mux    = in_data[i*DATA_W +: DATA_W];
`ifdef MUX_STREAM_N_PKT_LOCK_EN
                last_mux    = in_last[i];
`endif
            end
        end
    end

    // ---- output register stage (p1) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            data_p1    <= '0;
            ch_p1      <= '0;
            last_grant <= SEL_W'(NUM_CH - 1);
`ifdef MUX_STREAM_N_PKT_LOCK_EN
            last_p1    <= 1'b0;
            lock_vld   <= 1'b0;
            lock_ch    <= '0;
`endif
        end else if (grant_vld) begin
            vld_p1  <= 1'b1;
            data_p1 <= data_mux;
            ch_p1   <= grant;
            if (RR_MODE != 0) last_grant <= grant;
`ifdef MUX_STREAM_N_PKT_LOCK_EN
            last_p1  <= last_mux;
            lock_vld <= !last_mux;
            lock_ch  <= grant;
`endif
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_ch    = ch_p1;
`ifdef MUX_STREAM_N_PKT_LOCK_EN
    assign out_last  = last_p1;
`endif

endmodule

// File: tb/tb_mux_stream_n.sv
// Directed bench for mux_stream_n: select mode (8 and 6 channels) and round-robin mode.
// Packet-lock scenario is included when MUX_STREAM_N_PKT_LOCK_EN is defined.
module tb_mux_stream_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance a: select mode, 8 channels
    logic [2:0]  sel_a = '0;
    logic [7:0]  valid_a = '0, ready_a;
    logic [63:0] data_a = '0;
    logic        ovalid_a, oready_a = 1'b1;
    logic [7:0]  odata_a;
    logic [2:0]  och_a;
    // Instance b: round-robin mode, 8 channels
    logic [2:0]  sel_b = '0;
    logic [7:0]  valid_b = '0, ready_b;
    logic [63:0] data_b = '0;
    logic        ovalid_b, oready_b = 1'b1;
    logic [7:0]  odata_b;
    logic [2:0]  och_b;
    // Instance c: select mode, 6 channels
    logic [2:0]  sel_c = '0;
    logic [5:0]  valid_c = '0, ready_c;
    logic [47:0] data_c = '0;
    logic        ovalid_c, oready_c = 1'b1;
    logic [7:0]  odata_c;
    logic [2:0]  och_c;
`ifdef MUX_STREAM_N_PKT_LOCK_EN
    logic [7:0]  last_a = '0, last_b = '0;
    logic [5:0]  last_c = '0;
    logic        olast_a, olast_b, olast_c;
`endif

    mux_stream_n #(.NUM_CH(8), .DATA_W(8), .SEL_W(3), .RR_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .sel(sel_a), .in_valid(valid_a), .in_data(data_a),
`ifdef MUX_STREAM_N_PKT_LOCK_EN
        .in_last(last_a), .out_last(olast_a),
`endif
        .in_ready(ready_a), .out_valid(ovalid_a), .out_data(odata_a), .out_ch(och_a),
        .out_ready(oready_a));

    mux_stream_n #(.NUM_CH(8), .DATA_W(8), .SEL_W(3), .RR_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .sel(sel_b), .in_valid(valid_b), .in_data(data_b),
`ifdef MUX_STREAM_N_PKT_LOCK_EN
        .in_last(last_b), .out_last(olast_b),
`endif
        .in_ready(ready_b), .out_valid(ovalid_b), .out_data(odata_b), .out_ch(och_b),
        .out_ready(oready_b));

    mux_stream_n #(.NUM_CH(6), .DATA_W(8), .SEL_W(3), .RR_MODE(0)) dut_c (
        .clk(clk), .rst(rst), .sel(sel_c), .in_valid(valid_c), .in_data(data_c),
`ifdef MUX_STREAM_N_PKT_LOCK_EN
        .in_last(last_c), .out_last(olast_c),
`endif
        .in_ready(ready_c), .out_valid(ovalid_c), .out_data(odata_c), .out_ch(och_c),
        .out_ready(oready_c));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_a = 8'hFF;
        valid_b = 8'hFF;
        valid_c = 6'h3F;
        step();
        total++; if (ovalid_a !== 1'b0) begin bad++; $display("FAIL rst_valid_a got=%0h exp=0", ovalid_a); end
        total++; if (odata_a !== 8'h00) begin bad++; $display("FAIL rst_data_a got=%0h exp=0", odata_a); end
        total++; if (och_a !== 3'd0) begin bad++; $display("FAIL rst_ch_a got=%0h exp=0", och_a); end
        total++; if (ready_a !== 8'h00) begin bad++; $display("FAIL rst_ready_a got=%0h exp=0", ready_a); end
        total++; if (ready_b !== 8'h00) begin bad++; $display("FAIL rst_ready_b got=%0h exp=0", ready_b); end
        total++; if (ovalid_b !== 1'b0) begin bad++; $display("FAIL rst_valid_b got=%0h exp=0", ovalid_b); end
        valid_a = '0;
        valid_b = '0;
        valid_c = '0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_select();
        sel_a = 3'd5;
        valid_a = 8'h20;
        data_a[5*8 +: 8] = 8'hA5;
        oready_a = 1'b1;
        #1;
        total++; if (ready_a !== 8'h20) begin bad++; $display("FAIL sel_ready got=%0h exp=20", ready_a); end
        step();
        total++; if (ovalid_a !== 1'b1) begin bad++; $display("FAIL sel_valid got=%0h exp=1", ovalid_a); end
        total++; if (odata_a !== 8'hA5) begin bad++; $display("FAIL sel_data got=%0h exp=a5", odata_a); end
        total++; if (och_a !== 3'd5) begin bad++; $display("FAIL sel_ch got=%0h exp=5", och_a); end
        valid_a = '0;
        step();
        total++; if (ovalid_a !== 1'b0) begin bad++; $display("FAIL drain_valid got=%0h exp=0", ovalid_a); end
        total++; if (odata_a !== 8'hA5) begin bad++; $display("FAIL drain_hold got=%0h exp=a5", odata_a); end
        // selected channel idle while all others are valid
        valid_a = 8'hDF;
        #1;
        total++; if (ready_a !== 8'h00) begin bad++; $display("FAIL idle_ready got=%0h exp=0", ready_a); end
        step();
        total++; if (ovalid_a !== 1'b0) begin bad++; $display("FAIL idle_valid got=%0h exp=0", ovalid_a); end
        valid_a = '0;
    endtask

    task automatic test_sel_range();
        valid_c = 6'h3F;
        data_c[5*8 +: 8] = 8'h5C;
        sel_c = 3'd7;
        #1;
        total++; if (ready_c !== 6'h00) begin bad++; $display("FAIL range7_ready got=%0h exp=0", ready_c); end
        step();
        total++; if (ovalid_c !== 1'b0) begin bad++; $display("FAIL range7_valid got=%0h exp=0", ovalid_c); end
        sel_c = 3'd6;
        #1;
        total++; if (ready_c !== 6'h00) begin bad++; $display("FAIL range6_ready got=%0h exp=0", ready_c); end
        step();
        total++; if (ovalid_c !== 1'b0) begin bad++; $display("FAIL range6_valid got=%0h exp=0", ovalid_c); end
        sel_c = 3'd5;
        #1;
        total++; if (ready_c !== 6'h20) begin bad++; $display("FAIL range5_ready got=%0h exp=20", ready_c); end
        step();
        total++; if (ovalid_c !== 1'b1) begin bad++; $display("FAIL range5_valid got=%0h exp=1", ovalid_c); end
        total++; if (och_c !== 3'd5) begin bad++; $display("FAIL range5_ch got=%0h exp=5", och_c); end
        total++; if (odata_c !== 8'h5C) begin bad++; $display("FAIL range5_data got=%0h exp=5c", odata_c); end
        valid_c = '0;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_rdy;
        for (int i = 0; i < 8; i++) data_b[i*8 +: 8] = 8'h10 + 8'(i);
        valid_b = 8'hFF;
        oready_b = 1'b1;
        #1;
        total++; if (ready_b !== 8'h01) begin bad++; $display("FAIL rr_first_ready got=%0h exp=01", ready_b); end
        for (int i = 0; i < 10; i++) begin
            step();
            total++; if (ovalid_b !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d] got=%0h exp=1", i, ovalid_b); end
            total++; if (och_b !== 3'(i % 8)) begin bad++; $display("FAIL rr_ch[%0d] got=%0d exp=%0d", i, och_b, i % 8); end
            total++; if (odata_b !== 8'h10 + 8'(i % 8)) begin bad++; $display("FAIL rr_data[%0d] got=%0h exp=%0h", i, odata_b, 8'h10 + 8'(i % 8)); end
            exp_rdy = 8'h01 << ((i + 1) % 8);
            total++; if (ready_b !== exp_rdy) begin bad++; $display("FAIL rr_ready[%0d] got=%0h exp=%0h", i, ready_b, exp_rdy); end
        end
    endtask

    task automatic test_backpressure();
        sel_a = 3'd3;
        valid_a = 8'h08;
        data_a[3*8 +: 8] = 8'h33;
        data_a[1*8 +: 8] = 8'h11;
        oready_a = 1'b1;
        step();
        total++; if (odata_a !== 8'h33) begin bad++; $display("FAIL bp_load got=%0h exp=33", odata_a); end
        oready_a = 1'b0;
        sel_a = 3'd1;
        valid_a = 8'h02;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (ready_a !== 8'h00) begin bad++; $display("FAIL bp_ready[%0d] got=%0h exp=0", i, ready_a); end
            step();
            total++; if (odata_a !== 8'h33 || och_a !== 3'd3 || ovalid_a !== 1'b1) begin
                bad++; $display("FAIL bp_hold[%0d] got=%0h/%0d/%0b exp=33/3/1", i, odata_a, och_a, ovalid_a); end
        end
        oready_a = 1'b1;
        #1;
        total++; if (ready_a !== 8'h02) begin bad++; $display("FAIL bp_refill_ready got=%0h exp=02", ready_a); end
        step();
        total++; if (ovalid_a !== 1'b1 || odata_a !== 8'h11 || och_a !== 3'd1) begin
            bad++; $display("FAIL bp_refill got=%0b/%0h/%0d exp=1/11/1", ovalid_a, odata_a, och_a); end
        valid_a = '0;
    endtask

    task automatic test_reset_mid();
        valid_b = 8'hFF;
        total++; if (ovalid_b !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%0h exp=1", ovalid_b); end
        rst = 1'b1;
        #1;
        total++; if (ready_b !== 8'h00) begin bad++; $display("FAIL mid_rst_ready got=%0h exp=0", ready_b); end
        step();
        total++; if (ovalid_b !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%0h exp=0", ovalid_b); end
        total++; if (ready_b !== 8'h00) begin bad++; $display("FAIL mid_rst_ready2 got=%0h exp=0", ready_b); end
        rst = 1'b0;
        #1;
        total++; if (ready_b !== 8'h01) begin bad++; $display("FAIL mid_rel_ready got=%0h exp=01", ready_b); end
        step();
        total++; if (och_b !== 3'd0) begin bad++; $display("FAIL mid_rel_ch got=%0d exp=0", och_b); end
        // wrap-around between the two end channels
        valid_b = 8'h81;
        step();
        total++; if (och_b !== 3'd7) begin bad++; $display("FAIL wrap_ch7 got=%0d exp=7", och_b); end
        step();
        total++; if (och_b !== 3'd0) begin bad++; $display("FAIL wrap_ch0 got=%0d exp=0", och_b); end
        valid_b = '0;
        step();
    endtask

`ifdef MUX_STREAM_N_PKT_LOCK_EN
    task automatic test_pkt_lock();
        rst = 1'b1;
        step();
        rst = 1'b0;
        valid_b = 8'h0C;
        last_b = 8'h00;
        oready_b = 1'b1;
        step();
        total++; if (och_b !== 3'd2 || olast_b !== 1'b0) begin bad++; $display("FAIL lock_b1 got=%0d/%0b exp=2/0", och_b, olast_b); end
        step();
        total++; if (och_b !== 3'd2 || olast_b !== 1'b0) begin bad++; $display("FAIL lock_b2 got=%0d/%0b exp=2/0", och_b, olast_b); end
        last_b = 8'h04;
        step();
        total++; if (och_b !== 3'd2 || olast_b !== 1'b1) begin bad++; $display("FAIL lock_b3 got=%0d/%0b exp=2/1", och_b, olast_b); end
        last_b = 8'h08;
        step();
        total++; if (och_b !== 3'd3) begin bad++; $display("FAIL lock_release got=%0d exp=3", och_b); end
        valid_b = '0;
        last_b = '0;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_select();
        test_sel_range();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
`ifdef MUX_STREAM_N_PKT_LOCK_EN
        test_pkt_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_stream_n.md
Name: mux_stream_n

Overview:
- Parametrised N-to-1 streaming multiplexer with a registered output. Generalises the combinational 8-to-1 select mux to NUM_CH channels of DATA_W bits, with valid/ready handshakes.
- Two arbitration modes: external select, or internal round-robin.
- Sits between multiple producer streams and a single consumer. Output is one register stage, so there is one cycle of latency.

Parameters:
- NUM_CH, 8, number of input channels (2..32).
- DATA_W, 8, data width per channel.
- SEL_W, 3, width of select and of out_ch. Must satisfy 2**SEL_W >= NUM_CH.
- RR_MODE, 0, 0 = select-driven arbitration; 1 = round-robin arbitration (the sel port is ignored).

Ports:
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- sel  in  SEL_W  channel select, used only when RR_MODE=0.
- in_valid  in  NUM_CH  per-channel valid; bit i belongs to channel i.
- in_data  in  NUM_CH*DATA_W  flat data bus; channel i is at bits [i*DATA_W +: DATA_W].
- in_ready  out  NUM_CH  per-channel ready; at most one bit is set per cycle.
- out_valid  out  1  output register holds a beat.
- out_data  out  DATA_W  registered data.
- out_ch  out  SEL_W  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts the beat.

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high. No asynchronous paths.
- Reset values: out_valid=0, out_data=0, out_ch=0, in_ready=0, round-robin pointer last_grant=NUM_CH-1 (so channel 0 has first priority).
- Load enable: load_en = !out_valid || out_ready. The output register may accept a new beat whenever it is empty or being drained in the same cycle.
- Grant (combinational, only when load_en=1):
  - RR_MODE=0: grant = sel if sel < NUM_CH and in_valid[sel]=1; otherwise no grant. sel >= NUM_CH never grants and never asserts any in_ready.
  - RR_MODE=1: grant = first i with in_valid[i]=1, scanning last_grant+1, last_grant+2, ... modulo NUM_CH (wrap from NUM_CH-1 to 0). If no in_valid bit is set, no grant.
- in_ready[i] = load_en && (i == grant) && no reset. in_ready never depends on in_valid of other channels except through grant.
- Transfer: in_valid[g] && in_ready[g]. On a transfer:
  - out_data <= in_data[g]; out_ch <= g; out_valid <= 1.
  - In RR_MODE=1, last_grant <= g.
- Output drains with no refill (out_valid && out_ready, no transfer): out_valid <= 0. out_data and out_ch hold their last values.
- Simultaneous drain and refill: the register takes the new beat, out_valid stays 1, and throughput is 1 beat/cycle.
- Stall: out_valid=1 and out_ready=0 → all in_ready=0; out_data and out_ch stay stable until accepted. Producers must hold data stable while valid.
- Latency: a beat accepted at edge k appears on out_* immediately after edge k and remains until the consumer handshakes.
- Reset mid-operation: the beat held in the output register is discarded, out_valid drops on the reset edge, and the pointer returns to its reset value. An in-flight input beat is not transferred (in_ready=0 while rst=1).
- sel changing while stalled has no effect on the held beat. The new sel is used at the next load_en cycle.
- Width rules: out_ch is zero-extended channel index. DATA_W must be >= 1.

Optional Feature:
- Macro: MUX_STREAM_N_PKT_LOCK_EN
- Defined:
  - Adds input port in_last (NUM_CH) and output port out_last (1).
  - Once a channel is granted with in_last[g]=0, the grant locks to that channel. Locking ignores sel and round-robin until a beat with in_last[g]=1 transfers. The lock is released on that edge.
  - out_last is registered with the beat; its reset value is 0.
  - Reset clears the lock.
- Undefined: no in_last or out_last ports; arbitration is re-evaluated every beat.

Test Plan:
- RR_MODE=0, sel=5, in_valid=8'h20, in_data ch5=8'hA5, out_ready=1 → in_ready=8'h20; next cycle out_valid=1, out_data=8'hA5, out_ch=5.
- RR_MODE=0, sel=5, in_valid=8'hDF (ch5 idle) → in_ready=0 and out_valid stays 0. Also sel=7 with NUM_CH=6 → no grant.
- RR_MODE=1, all in_valid=8'hFF for 10 cycles, out_ready=1 → out_ch sequence 0,1,...,7,0,1 with no gaps.
- Backpressure: beat held with out_ready=0 for 3 cycles → out_data and out_ch constant, in_ready=0. Then out_ready=1 with a new valid → a new beat loads on the same edge, with no bubble.
- Reset mid-stream: rst=1 while out_valid=1 → next cycle out_valid=0 and in_ready=0. After release, RR grants ch0 first.
- With MUX_STREAM_N_PKT_LOCK_EN and RR_MODE=1: ch2 sends a 3-beat packet (last on beat 3) while ch3 is valid → out_ch=2,2,2 then 3.
